// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage: instruction-decode stage of a 5-stage MIPS32 pipeline.
//
// Holds the IF/ID latch, the 32x32 register file and the ID/EX register.
// BEQ/BNE are resolved here; taken-branch, offset and stall go back to fetch.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_if_pc, i_if_instruction PC / instruction from fetch
//   i_wb_write_en/dest/value  writeback port into the register file
//   i_ex_wb_en, i_ex_mem_read, i_ex_dest   EX-stage instruction info (hazards)
//   i_mem_wb_en, i_mem_dest                MEM-stage instruction info (hazards)
//   o_branch_taken, o_branch_offset, o_freeze   combinational, to fetch
//   o_id_ex_*                 registered ID/EX bundle
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int WORD_LEN  = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [WORD_LEN-1:0] i_if_pc,
  input  logic [WORD_LEN-1:0] i_if_instruction,
  input  logic                i_wb_write_en,
  input  logic [4:0]          i_wb_dest,
  input  logic [WORD_LEN-1:0] i_wb_value,
  input  logic                i_ex_wb_en,
  input  logic                i_ex_mem_read,
  input  logic [4:0]          i_ex_dest,
  input  logic                i_mem_wb_en,
  input  logic [4:0]          i_mem_dest,
  output logic                o_branch_taken,
  output logic [WORD_LEN-1:0] o_branch_offset,
  output logic                o_freeze,
  output logic                o_id_ex_valid,
  output logic [WORD_LEN-1:0] o_id_ex_pc,
  output logic [WORD_LEN-1:0] o_id_ex_val1,
  output logic [WORD_LEN-1:0] o_id_ex_val2,
  output logic [WORD_LEN-1:0] o_id_ex_imm,
  output logic [4:0]          o_id_ex_dest,
  output logic [3:0]          o_id_ex_alu_cmd,
  output logic                o_id_ex_mem_read,
  output logic                o_id_ex_mem_write,
  output logic                o_id_ex_wb_en
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic                r_if_valid;
  logic [WORD_LEN-1:0] r_if_pc;
  logic [WORD_LEN-1:0] r_if_instr;
  logic [WORD_LEN-1:0] r_regs [REG_COUNT];

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic [4:0]          w_rd;
  logic [WORD_LEN-1:0] w_imm;
  logic [WORD_LEN-1:0] w_val1;
  logic [WORD_LEN-1:0] w_val2;
  logic [3:0]          w_alu_cmd;
  logic [4:0]          w_dest;
  logic                w_wb;
  logic                w_wb_en;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_uses_rt;
  logic                w_is_beq;
  logic                w_is_bne;
  logic                w_load_use;
  logic                w_branch_haz;
  logic                w_freeze;
  logic                w_taken;

  assign w_op    = r_if_instr[31:26];
  assign w_rs    = r_if_instr[25:21];
  assign w_rt    = r_if_instr[20:16];
  assign w_rd    = r_if_instr[15:11];
  assign w_funct = r_if_instr[5:0];
  assign w_imm   = {{(WORD_LEN-16){r_if_instr[15]}}, r_if_instr[15:0]};

  // Non-writing instructions carry dest 0 so the ID/EX bundle never names a
  // register it will not write.
  always_comb begin
    w_alu_cmd   = 4'd0;
    w_dest      = 5'd0;
    w_wb        = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_uses_rt   = 1'b0;
    w_is_beq    = 1'b0;
    w_is_bne    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        case (w_funct)
          F_ADD: begin w_wb = 1'b1; w_dest = w_rd; w_alu_cmd = 4'd0; end
          F_SUB: begin w_wb = 1'b1; w_dest = w_rd; w_alu_cmd = 4'd1; end
          F_AND: begin w_wb = 1'b1; w_dest = w_rd; w_alu_cmd = 4'd2; end
          F_OR:  begin w_wb = 1'b1; w_dest = w_rd; w_alu_cmd = 4'd3; end
          F_SLT: begin w_wb = 1'b1; w_dest = w_rd; w_alu_cmd = 4'd4; end
          default: ;
        endcase
      end
      OP_ADDI: begin w_wb = 1'b1; w_dest = w_rt; end
      OP_LW:   begin w_wb = 1'b1; w_dest = w_rt; w_mem_read = 1'b1; end
      OP_SW:   begin w_mem_write = 1'b1; w_uses_rt = 1'b1; end
      OP_BEQ:  begin w_is_beq = 1'b1; w_uses_rt = 1'b1; end
      OP_BNE:  begin w_is_bne = 1'b1; w_uses_rt = 1'b1; end
      default: ;
    endcase
  end

  assign w_wb_en = w_wb & (w_dest != 5'd0);

  // Write-through: a same-cycle writeback to the read index wins over the array.
  assign w_val1 = (w_rs == 5'd0) ? '0 :
                  (i_wb_write_en && (i_wb_dest == w_rs)) ? i_wb_value : r_regs[w_rs];
  assign w_val2 = (w_rt == 5'd0) ? '0 :
                  (i_wb_write_en && (i_wb_dest == w_rt)) ? i_wb_value : r_regs[w_rt];

  assign w_load_use = r_if_valid && i_ex_mem_read && (i_ex_dest != 5'd0) &&
                      ((i_ex_dest == w_rs) || (w_uses_rt && (i_ex_dest == w_rt)));

  // Branches compare in ID, so any in-flight producer of an operand stalls.
  assign w_branch_haz = r_if_valid && (w_is_beq || w_is_bne) &&
                        ((i_ex_wb_en && (i_ex_dest != 5'd0) &&
                          ((i_ex_dest == w_rs) || (i_ex_dest == w_rt))) ||
                         (i_mem_wb_en && (i_mem_dest != 5'd0) &&
                          ((i_mem_dest == w_rs) || (i_mem_dest == w_rt))));

  assign w_freeze = w_load_use || w_branch_haz;
  assign w_taken  = r_if_valid && !w_freeze &&
                    ((w_is_beq && (w_val1 == w_val2)) || (w_is_bne && (w_val1 != w_val2)));

  assign o_freeze        = w_freeze;
  assign o_branch_taken  = w_taken;
  assign o_branch_offset = w_imm;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      o_id_ex_valid     <= 1'b0;
      o_id_ex_pc        <= '0;
      o_id_ex_val1      <= '0;
      o_id_ex_val2      <= '0;
      o_id_ex_imm       <= '0;
      o_id_ex_dest      <= 5'd0;
      o_id_ex_alu_cmd   <= 4'd0;
      o_id_ex_mem_read  <= 1'b0;
      o_id_ex_mem_write <= 1'b0;
      o_id_ex_wb_en     <= 1'b0;
    end else begin
      if (i_wb_write_en && (i_wb_dest != 5'd0)) r_regs[i_wb_dest] <= i_wb_value;

      if (w_freeze) begin
        // hold the latch
      end else if (w_taken) begin
        r_if_valid <= 1'b0;
        r_if_pc    <= '0;
        r_if_instr <= '0;
      end else begin
        r_if_valid <= 1'b1;
        r_if_pc    <= i_if_pc;
        r_if_instr <= i_if_instruction;
      end

      if (w_freeze) begin
        o_id_ex_valid     <= 1'b0;
        o_id_ex_pc        <= '0;
        o_id_ex_val1      <= '0;
        o_id_ex_val2      <= '0;
        o_id_ex_imm       <= '0;
        o_id_ex_dest      <= 5'd0;
        o_id_ex_alu_cmd   <= 4'd0;
        o_id_ex_mem_read  <= 1'b0;
        o_id_ex_mem_write <= 1'b0;
        o_id_ex_wb_en     <= 1'b0;
      end else begin
        o_id_ex_valid     <= r_if_valid;
        o_id_ex_pc        <= r_if_pc;
        o_id_ex_val1      <= w_val1;
        o_id_ex_val2      <= w_val2;
        o_id_ex_imm       <= w_imm;
        o_id_ex_dest      <= w_dest;
        o_id_ex_alu_cmd   <= w_alu_cmd;
        o_id_ex_mem_read  <= w_mem_read;
        o_id_ex_mem_write <= w_mem_write;
        o_id_ex_wb_en     <= w_wb_en;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] if_pc, if_instruction;
  logic        wb_write_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic        ex_wb_en, ex_mem_read;
  logic [4:0]  ex_dest;
  logic        mem_wb_en;
  logic [4:0]  mem_dest;

  logic        branch_taken, freeze;
  logic [31:0] branch_offset;
  logic        id_ex_valid, id_ex_mem_read, id_ex_mem_write, id_ex_wb_en;
  logic [31:0] id_ex_pc, id_ex_val1, id_ex_val2, id_ex_imm;
  logic [4:0]  id_ex_dest;
  logic [3:0]  id_ex_alu_cmd;

  id_stage dut (
    .i_clk(clk), .i_reset(reset), .i_if_pc(if_pc), .i_if_instruction(if_instruction),
    .i_wb_write_en(wb_write_en), .i_wb_dest(wb_dest), .i_wb_value(wb_value),
    .i_ex_wb_en(ex_wb_en), .i_ex_mem_read(ex_mem_read), .i_ex_dest(ex_dest),
    .i_mem_wb_en(mem_wb_en), .i_mem_dest(mem_dest),
    .o_branch_taken(branch_taken), .o_branch_offset(branch_offset), .o_freeze(freeze),
    .o_id_ex_valid(id_ex_valid), .o_id_ex_pc(id_ex_pc), .o_id_ex_val1(id_ex_val1),
    .o_id_ex_val2(id_ex_val2), .o_id_ex_imm(id_ex_imm), .o_id_ex_dest(id_ex_dest),
    .o_id_ex_alu_cmd(id_ex_alu_cmd), .o_id_ex_mem_read(id_ex_mem_read),
    .o_id_ex_mem_write(id_ex_mem_write), .o_id_ex_wb_en(id_ex_wb_en)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  dest;
    logic [3:0]  alu;
    logic        mr, mw, wb;
  } idex_t;

  typedef struct {
    logic       wb, mr, mw, uses_rt, beq, bne;
    logic [3:0] alu;
    logic [4:0] dest;
  } dec_t;

  idex_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference state: architectural registers and the instruction sitting in ID
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    d = '{default: '0};
    if (op == 6'h00) begin
      d.uses_rt = 1'b1;
      if (fn == 6'h20)      begin d.wb = 1; d.alu = 0; end
      else if (fn == 6'h22) begin d.wb = 1; d.alu = 1; end
      else if (fn == 6'h24) begin d.wb = 1; d.alu = 2; end
      else if (fn == 6'h25) begin d.wb = 1; d.alu = 3; end
      else if (fn == 6'h2A) begin d.wb = 1; d.alu = 4; end
      if (d.wb) d.dest = ins[15:11];
    end else if (op == 6'h08) begin
      d.wb = 1; d.dest = ins[20:16];
    end else if (op == 6'h23) begin
      d.wb = 1; d.mr = 1; d.dest = ins[20:16];
    end else if (op == 6'h2B) begin
      d.mw = 1; d.uses_rt = 1;
    end else if (op == 6'h04) begin
      d.beq = 1; d.uses_rt = 1;
    end else if (op == 6'h05) begin
      d.bne = 1; d.uses_rt = 1;
    end
    if (d.dest == 5'd0) d.wb = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_write_en && wb_dest == idx) return wb_value;
    return m_regs[idx];
  endfunction

  // One cycle: called just after a falling edge with inputs already driven.
  // Checks the combinational outputs, queues the expected ID/EX bundle and
  // advances the reference state across the rising edge.
  task automatic step();
    dec_t d;
    idex_t e;
    logic [4:0] rs, rt;
    logic [31:0] v1, v2, imm;
    logic lu, bh, frz, tk;
    #1;
    d   = ref_decode(m_instr);
    rs  = m_instr[25:21];
    rt  = m_instr[20:16];
    v1  = rd_reg(rs);
    v2  = rd_reg(rt);
    imm = {{16{m_instr[15]}}, m_instr[15:0]};
    lu  = m_valid && ex_mem_read && ex_dest != 0 &&
          (ex_dest == rs || (d.uses_rt && ex_dest == rt));
    bh  = m_valid && (d.beq || d.bne) &&
          ((ex_wb_en && ex_dest != 0 && (ex_dest == rs || ex_dest == rt)) ||
           (mem_wb_en && mem_dest != 0 && (mem_dest == rs || mem_dest == rt)));
    frz = lu || bh;
    tk  = m_valid && !frz && ((d.beq && v1 == v2) || (d.bne && v1 != v2));
    chk("freeze", {31'd0, freeze}, {31'd0, frz});
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, tk});
    chk("branch_offset", branch_offset, imm);

    e = '{default: '0};
    if (!reset && !frz) begin
      e.valid = m_valid; e.pc = m_pc; e.v1 = v1; e.v2 = v2; e.imm = imm;
      e.dest = d.dest; e.alu = d.alu; e.mr = d.mr; e.mw = d.mw; e.wb = d.wb;
    end
    sb_q.push_back(e);

    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 0; m_pc = 0; m_instr = 0;
    end else begin
      if (wb_write_en && wb_dest != 0) m_regs[wb_dest] = wb_value;
      if (!frz) begin
        if (tk) begin
          m_valid = 0; m_pc = 0; m_instr = 0;
        end else begin
          m_valid = 1; m_pc = if_pc; m_instr = if_instruction;
        end
      end
    end
    @(negedge clk);
  endtask

  // Monitor: the ID/EX bundle is presented every cycle, compare after each edge.
  initial begin
    idex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("id_ex_valid", {31'd0, id_ex_valid}, {31'd0, e.valid});
        if (e.valid) chk("id_ex_pc", id_ex_pc, e.pc);
        chk("id_ex_val1", id_ex_val1, e.v1);
        chk("id_ex_val2", id_ex_val2, e.v2);
        chk("id_ex_imm", id_ex_imm, e.imm);
        chk("id_ex_dest", {27'd0, id_ex_dest}, {27'd0, e.dest});
        chk("id_ex_alu_cmd", {28'd0, id_ex_alu_cmd}, {28'd0, e.alu});
        chk("id_ex_mem_read", {31'd0, id_ex_mem_read}, {31'd0, e.mr});
        chk("id_ex_mem_write", {31'd0, id_ex_mem_write}, {31'd0, e.mw});
        chk("id_ex_wb_en", {31'd0, id_ex_wb_en}, {31'd0, e.wb});
      end
    end
  end

  task automatic idle();
    reset = 0; if_pc = $urandom; if_instruction = 32'd0;
    wb_write_en = 0; wb_dest = 0; wb_value = 0;
    ex_wb_en = 0; ex_mem_read = 0; ex_dest = 0; mem_wb_en = 0; mem_dest = 0;
  endtask

  task automatic rand_inputs();
    int k;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3, 4: if_instruction = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                            5'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
      5: if_instruction = itype(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      6: if_instruction = itype(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      7: if_instruction = itype(6'h2B, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      8: if_instruction = itype(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05,
                                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      default: if_instruction = $urandom;
    endcase
    reset       = ($urandom_range(0, 99) < 2);
    if_pc       = $urandom;
    wb_write_en = ($urandom_range(0, 1) != 0);
    wb_dest     = 5'($urandom_range(0, 7));
    wb_value    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
    ex_mem_read = ($urandom_range(0, 4) == 0);
    ex_wb_en    = ($urandom_range(0, 3) == 0);
    ex_dest     = 5'($urandom_range(0, 7));
    mem_wb_en   = ($urandom_range(0, 3) == 0);
    mem_dest    = 5'($urandom_range(0, 7));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_pc = 0; m_instr = 0;
    idle();

    // reset with random inputs for two cycles
    rand_inputs(); reset = 1; step();
    rand_inputs(); reset = 1; step();
    idle();
    chk("reset_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("reset_val1", id_ex_val1, 32'd0);
    // every register reads 0 after reset
    for (int i = 1; i < 32; i++) begin
      idle(); if_instruction = rtype(5'(i), 5'(32 - i), 5'd1, 6'h20); step();
    end

    // write-through into a same-cycle read
    idle(); if_instruction = rtype(5'd5, 5'd0, 5'd3, 6'h20); step();
    idle(); wb_write_en = 1; wb_dest = 5; wb_value = 32'h1234; step();
    chk("wt_val1", id_ex_val1, 32'h1234);
    chk("wt_dest", {27'd0, id_ex_dest}, 32'd3);
    chk("wt_wb_en", {31'd0, id_ex_wb_en}, 32'd1);

    // load-use stall
    idle(); if_instruction = rtype(5'd4, 5'd7, 5'd2, 6'h20); step();
    idle(); ex_mem_read = 1; ex_dest = 7; #1;
    chk("lu_freeze", {31'd0, freeze}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, id_ex_valid}, 32'd0);
    idle(); step();
    chk("lu_issue_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("lu_issue_dest", {27'd0, id_ex_dest}, 32'd2);

    // BEQ taken with R1 == R2 == 9
    idle(); wb_write_en = 1; wb_dest = 1; wb_value = 9; step();
    idle(); wb_write_en = 1; wb_dest = 2; wb_value = 9;
    if_instruction = itype(6'h04, 5'd1, 5'd2, 16'hFFFE); step();
    idle(); if_instruction = itype(6'h08, 5'd0, 5'd6, 16'd7); #1;
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_offset", branch_offset, 32'hFFFF_FFFE);
    step();
    chk("beq_in_idex", {31'd0, id_ex_valid}, 32'd1);
    chk("beq_no_wb", {31'd0, id_ex_wb_en}, 32'd0);
    idle(); step();
    chk("beq_squash", {31'd0, id_ex_valid}, 32'd0);

    // BNE operand hazard from MEM, then resolves taken (R1=9, R3=0)
    idle(); if_instruction = itype(6'h05, 5'd1, 5'd3, 16'd4); step();
    idle(); mem_wb_en = 1; mem_dest = 3; #1;
    chk("bne_freeze", {31'd0, freeze}, 32'd1);
    chk("bne_held", {31'd0, branch_taken}, 32'd0);
    step();
    idle(); #1;
    chk("bne_after", {31'd0, branch_taken}, 32'd1);
    step();

    // R0 protection
    idle(); wb_write_en = 1; wb_dest = 0; wb_value = 32'hFFFF;
    if_instruction = rtype(5'd0, 5'd0, 5'd4, 6'h20); step();
    idle(); if_instruction = itype(6'h08, 5'd1, 5'd0, 16'd5); step();
    chk("r0_read", id_ex_val1, 32'd0);
    idle(); step();
    chk("r0_valid", {31'd0, id_ex_valid}, 32'd1);
    chk("r0_wb_en", {31'd0, id_ex_wb_en}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end
    idle(); step();
    @(posedge clk); #2;
    chk("scoreboard_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
